// File: rtl/vga_timing_pkg.sv
// +----------------------------------------------------------------------+
// | vga_timing_pkg : 640x400 @ 70 Hz mode constants and counter widths    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_ACT  = 400;
  localparam int V_FP   = 12;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 35;
  localparam bit H_POL  = 1'b0;
  localparam bit V_POL  = 1'b1;

  localparam int FLASH_FRAMES = 32;

  localparam int H_TOTAL      = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACT + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACT + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int H_CNT_W = 10;
  localparam int V_CNT_W = 9;

  // A total of N needs counts 0..N-1, so N may equal 2**width.
  function automatic bit fits_width(input int total, input int width);
    return total <= (1 << width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +----------------------------------------------------------------------+
// | vga_axis_counter : wrapping raster counter with sync/active decode    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter #(
  parameter int WIDTH      = 10,
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751,
  parameter int ACT        = 640,
  parameter bit POL        = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             sync_o,
  output logic             act_nxt_o
);

  localparam logic [WIDTH-1:0] C_LAST  = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_SYNC0 = WIDTH'(SYNC_START);
  localparam logic [WIDTH-1:0] C_SYNC1 = WIDTH'(SYNC_END);
  localparam logic [WIDTH:0]   C_ACT   = (WIDTH+1)'(ACT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;

  assign tc_o = (cnt_q == C_LAST);

  // Decode from the next count so the registered sync lines up with it.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + C_ONE;
    end
    sync_d    = ((cnt_d >= C_SYNC0) && (cnt_d <= C_SYNC1)) ? POL : ~POL;
    act_nxt_o = ({1'b0, cnt_d} < C_ACT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +----------------------------------------------------------------------+
// | vga_timing_gen : raster counters, syncs, frame strobe and flash clock |
// | Optional flash logic: define VGA_TIMING_FLASH_EN.   Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACT        = vga_timing_pkg::H_ACT,
  parameter int H_FP         = vga_timing_pkg::H_FP,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_BP         = vga_timing_pkg::H_BP,
  parameter int V_ACT        = vga_timing_pkg::V_ACT,
  parameter int V_FP         = vga_timing_pkg::V_FP,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_BP         = vga_timing_pkg::V_BP,
  parameter bit H_POL        = vga_timing_pkg::H_POL,
  parameter bit V_POL        = vga_timing_pkg::V_POL,
  parameter int FLASH_FRAMES = vga_timing_pkg::FLASH_FRAMES
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                pixEn,
  output logic [vga_timing_pkg::H_CNT_W-1:0]  pixelCnt,
  output logic [vga_timing_pkg::V_CNT_W-1:0]  lineCnt,
  output logic                                hSync,
  output logic                                vSync,
  output logic                                activeEn,
  output logic                                frameStart,
  output logic                                flashClk
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  if (!fits_width(H_TOTAL, H_CNT_W) || !fits_width(V_TOTAL, V_CNT_W) ||
      (FLASH_FRAMES < 1)) begin : g_bad_geometry
    $error("vga_timing_gen: mode totals exceed counter widths");
  end

  logic h_tc, h_act_nxt;
  logic v_tc, v_act_nxt;
  logic line_en, frame_wrap;
  logic active_q, active_d;
  logic frame_start_q, frame_start_d;

  assign line_en    = pixEn & h_tc;
  assign frame_wrap = line_en & v_tc;

  vga_axis_counter #(
    .WIDTH      (H_CNT_W),
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACT + H_FP),
    .SYNC_END   (H_ACT + H_FP + H_SYNC - 1),
    .ACT        (H_ACT),
    .POL        (H_POL)
  ) u_h_axis (
    .clk_i     (clock),
    .rst_i     (reset),
    .en_i      (pixEn),
    .cnt_o     (pixelCnt),
    .tc_o      (h_tc),
    .sync_o    (hSync),
    .act_nxt_o (h_act_nxt)
  );

  vga_axis_counter #(
    .WIDTH      (V_CNT_W),
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACT + V_FP),
    .SYNC_END   (V_ACT + V_FP + V_SYNC - 1),
    .ACT        (V_ACT),
    .POL        (V_POL)
  ) u_v_axis (
    .clk_i     (clock),
    .rst_i     (reset),
    .en_i      (line_en),
    .cnt_o     (lineCnt),
    .tc_o      (v_tc),
    .sync_o    (vSync),
    .act_nxt_o (v_act_nxt)
  );

  always_comb begin
    active_d      = h_act_nxt & v_act_nxt;
    frame_start_d = frame_wrap;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign activeEn   = active_q;
  assign frameStart = frame_start_q;

`ifdef VGA_TIMING_FLASH_EN
  localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FLASH_W-1:0] C_FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);
  localparam logic [FLASH_W-1:0] C_FLASH_ONE  = FLASH_W'(1);

  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_q, flash_d;

  // Updated on the same edge that raises frameStart, so the toggle lands on (0,0).
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    if (frame_wrap) begin
      if (flash_cnt_q == C_FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_d     = ~flash_q;
      end else begin
        flash_cnt_d = flash_cnt_q + C_FLASH_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
    end
  end

  assign flashClk = flash_q;
`else
  assign flashClk = 1'b0;
`endif

endmodule

`default_nettype wire
